arm_exc_sequencer: RTL and testbench
====================================

# arm_exc_sequencer

Multi-cycle control sequencer for the ARM model CPU. It replaces the single-IRQ control FSM with one that handles `NUM_IRQ` prioritised, individually enabled IRQ lines plus one FIQ line. It performs banked-mode exception entry (LR, SPSR, CPSR, vector) and `MOVS PC` exception return. It sits between the instruction/CPSR registers and the datapath, and drives every datapath write enable and mux select.

## Interface
- `NUM_IRQ`, default 4: number of IRQ request lines, legal range 1..16.
- `IRQ_VEC_BASE`, default 32'h0000_0100: base of the vectored IRQ table (used only with the macro).
- `clk`  in  1  clock; all state and outputs update on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `irq_req`  in  NUM_IRQ  level IRQ requests.
- `irq_en`  in  NUM_IRQ  per-line enable.
- `fiq_req`  in  1  level FIQ request.
- `ir`  in  32  current instruction.
- `cpsr`  in  32  current CPSR; bit 7 = I, bit 6 = F.
- Control outputs, all registered:
  - `write_reg`, `write_pc`, `write_ir`, `write_cpsr`, `write_spsr`, `s`, `sp_in`, `sp_out`, `w_spsr_s`  out  1 each.
  - `w_rdata_s`, `rd_s`, `alu_a_s`, `pc_s`  out  2 each.
  - `w_cpsr_s`, `change_m`  out  3 each.
  - `alu_op`  out  4.
- `inta`  out  NUM_IRQ  one-hot IRQ acknowledge.
- `fiqa`  out  1  FIQ acknowledge.
- `irq_id`  out  clog2(NUM_IRQ) (min 1)  latched serviced line.
- `exc_vec`  out  32  vector address for `pc_s`=3.
- `st`, `next_st`  out  5  current and next state, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, RET_ALU=4, RET_WB=5, CHECK=6, EXC_LR=7, EXC_SAVE=8, EXC_JUMP=9. Any other code → FETCH.
- Transitions:
  - IDLE→FETCH→DECODE.
  - DECODE→RET_ALU when `ir[27:25]`=0, `ir[4]`=0 and `ir[15:12]`=4'hF; otherwise DECODE→EXEC.
  - EXEC→CHECK.
  - RET_ALU→RET_WB→CHECK.
  - CHECK→EXC_LR if an exception is taken, otherwise CHECK→FETCH.
  - EXC_LR→EXC_SAVE→EXC_JUMP→CHECK.
- Taking an exception in CHECK:
  - FIQ is taken if `fiq_req` & !`cpsr[6]`.
  - Otherwise IRQ is taken if |(`irq_req` & `irq_en`) & !`cpsr[7]`; the lowest index wins.
  - FIQ always beats IRQ.
  - The kind (FIQ/IRQ) and `irq_id` are latched on the CHECK→EXC_LR edge and held until the next take.
- Outputs are registered from `next_st`. Every output not listed for a state is 0 in that state.
  - FETCH: `write_pc`=1, `pc_s`=0, `write_ir`=1.
  - DECODE: all 0.
  - EXEC: `write_reg`=1, `alu_op`=`ir[24:21]`, `s`=`ir[20]`.
  - RET_ALU: `alu_op`=4'b1000, `s`=1.
  - RET_WB: `alu_op`=4'b1000, `write_pc`=1, `pc_s`=2, `write_cpsr`=1, `w_cpsr_s`=0 (CPSR←SPSR), `sp_out`=1.
  - CHECK: `sp_in`=1.
  - EXC_LR: `alu_op`=4'b1000, `alu_a_s`=1.
  - EXC_SAVE: `alu_op`=4'b1000, `alu_a_s`=1, `change_m`=M, `rd_s`=1, `w_rdata_s`=0, `write_reg`=1, `write_spsr`=1, `w_spsr_s`=1.
  - EXC_JUMP: `change_m`=M, `write_cpsr`=1, `w_cpsr_s`=W, `write_pc`=1, `pc_s`=3, plus `fiqa`=1 or `inta[irq_id]`=1.
  - For IRQ: M=3'b001, W=3'b010. For FIQ: M=3'b010, W=3'b011.
- `exc_vec`: 32'h1C for FIQ, 32'h18 for IRQ (see Configuration).

## Timing
- Reset:
  - `st`=IDLE.
  - Every output is 0, including `irq_id` and `exc_vec`.
  - `rst` asserted in any state aborts immediately (asynchronous); `inta`/`fiqa` drop in the same cycle.
- Ordinary instruction: 4 cycles (FETCH, DECODE, EXEC, CHECK).
- `MOVS PC`: 5 cycles.
- Exception entry: 3 cycles after CHECK. `inta`/`fiqa` are high for exactly one cycle (EXC_JUMP).
  - Sources must drop their request within one cycle of ack; a still-high request is re-evaluated at the next CHECK.
- `cpsr` reflects the EXC_JUMP write by the following CHECK, so:
  - an IRQ cannot re-enter itself;
  - FIQ pending with F=0 pre-empts immediately after IRQ entry (CHECK→EXC_LR again).
- Request changes after the latch edge do not alter the current entry.

## Configuration
- `VECTORED_IRQ_EN` defined: IRQ `exc_vec` = `IRQ_VEC_BASE` + (`irq_id` << 2), registered with the other outputs.
- `VECTORED_IRQ_EN` undefined: IRQ `exc_vec` = 32'h18 for every line; `irq_id` is still reported.
- FIQ vector is 32'h1C in both builds.

## Test plan
- Reset released with no requests, `ir`=data-processing → `st` cycles 1,2,3,6,1; FETCH has `write_pc`=`write_ir`=1, all others 0.
- `ir`=32'hE1B0F00E (`MOVS PC,LR`) → DECODE→RET_ALU→RET_WB with `pc_s`=2, `write_cpsr`=1, `w_cpsr_s`=0, then CHECK.
- `irq_req`=4'b1010, `irq_en`=4'hF, `cpsr[7]`=0 → `irq_id`=1, EXC_SAVE `change_m`=1, EXC_JUMP `inta`=4'b0010 for one cycle, `exc_vec`=32'h104 (vectored) or 32'h18.
- `fiq_req`=1 and `irq_req[0]`=1, `cpsr[7:6]`=0 → `fiqa`=1, `w_cpsr_s`=3, `exc_vec`=32'h1C, `inta`=0.
- `irq_req[2]`=1 with `cpsr[7]`=1 → CHECK→FETCH, no ack; also `irq_en[2]`=0 with I=0 → no take.
- `rst` pulsed during EXC_JUMP → `inta` falls asynchronously, `st`=IDLE, all outputs 0.

Source files
------------

// File: rtl/arm_exc_sequencer.sv
// arm_exc_sequencer: multi-cycle control sequencer for the ARM model CPU.
// Handles NUM_IRQ prioritised, individually enabled IRQ lines plus FIQ,
// banked-mode exception entry and MOVS PC exception return.
// Build option: VECTORED_IRQ_EN selects a per-line IRQ vector table at
// IRQ_VEC_BASE; otherwise every IRQ uses vector 32'h18.
module arm_exc_sequencer #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] IRQ_VEC_BASE = 32'h0000_0100,
    localparam int         ID_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               fiq_req,
    input  logic [31:0]        ir,
    input  logic [31:0]        cpsr,
    output logic               write_reg,
    output logic               write_pc,
    output logic               write_ir,
    output logic               write_cpsr,
    output logic               write_spsr,
    output logic               s,
    output logic               sp_in,
    output logic               sp_out,
    output logic               w_spsr_s,
    output logic [1:0]         w_rdata_s,
    output logic [1:0]         rd_s,
    output logic [1:0]         alu_a_s,
    output logic [1:0]         pc_s,
    output logic [2:0]         w_cpsr_s,
    output logic [2:0]         change_m,
    output logic [3:0]         alu_op,
    output logic [NUM_IRQ-1:0] inta,
    output logic               fiqa,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        exc_vec,
    output logic [4:0]         st,
    output logic [4:0]         next_st
);

    typedef enum logic [4:0] {
        IDLE     = 5'd0,
        FETCH    = 5'd1,
        DECODE   = 5'd2,
        EXEC     = 5'd3,
        RET_ALU  = 5'd4,
        RET_WB   = 5'd5,
        CHECK    = 5'd6,
        EXC_LR   = 5'd7,
        EXC_SAVE = 5'd8,
        EXC_JUMP = 5'd9
    } state_t;

`ifdef VECTORED_IRQ_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    state_t            st_q, nst;
    logic              exc_fiq_q;
    logic [NUM_IRQ-1:0] irq_hit;
    logic              irq_found, fiq_take, irq_take, movs_pc;
    logic [ID_W-1:0]   irq_sel;
    logic [31:0]       irq_vec;

    logic              write_reg_d, write_pc_d, write_ir_d, write_cpsr_d, write_spsr_d;
    logic              s_d, sp_in_d, sp_out_d, w_spsr_s_d, fiqa_d;
    logic [1:0]        w_rdata_s_d, rd_s_d, alu_a_s_d, pc_s_d;
    logic [2:0]        w_cpsr_s_d, change_m_d;
    logic [3:0]        alu_op_d;
    logic [NUM_IRQ-1:0] inta_d;

    logic unused_bits;
    assign unused_bits = ^{ir[31:28], ir[19:16], ir[11:5], ir[3:0], cpsr[31:8], cpsr[5:0]};

    assign st      = st_q;
    assign next_st = rst ? IDLE : nst;
    assign movs_pc = (ir[27:25] == 3'b000) && !ir[4] && (ir[15:12] == 4'hF);

    // Exception arbitration: FIQ over IRQ, lowest enabled IRQ line wins
    always_comb begin
        irq_hit   = irq_req & irq_en;
        irq_sel   = '0;
        irq_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (irq_hit[i] && !irq_found) begin
                irq_sel   = ID_W'(i);
                irq_found = 1'b1;
            end
        end
        fiq_take = fiq_req & ~cpsr[6];
        irq_take = irq_found & ~cpsr[7];
        irq_vec  = VECTORED ? IRQ_VEC_BASE + (32'(irq_sel) << 2) : 32'h0000_0018;
    end

    // Next-state logic
    always_comb begin
        nst = FETCH;
        case (st_q)
            IDLE:     nst = FETCH;
            FETCH:    nst = DECODE;
            DECODE:   nst = movs_pc ? RET_ALU : EXEC;
            EXEC:     nst = CHECK;
            RET_ALU:  nst = RET_WB;
            RET_WB:   nst = CHECK;
            CHECK:    nst = (fiq_take || irq_take) ? EXC_LR : FETCH;
            EXC_LR:   nst = EXC_SAVE;
            EXC_SAVE: nst = EXC_JUMP;
            EXC_JUMP: nst = CHECK;
            default:  nst = FETCH;
        endcase
    end

    // Control word for the state being entered; registered below
    always_comb begin
        write_reg_d  = 1'b0;
        write_pc_d   = 1'b0;
        write_ir_d   = 1'b0;
        write_cpsr_d = 1'b0;
        write_spsr_d = 1'b0;
        s_d          = 1'b0;
        sp_in_d      = 1'b0;
        sp_out_d     = 1'b0;
        w_spsr_s_d   = 1'b0;
        fiqa_d       = 1'b0;
        w_rdata_s_d  = '0;
        rd_s_d       = '0;
        alu_a_s_d    = '0;
        pc_s_d       = '0;
        w_cpsr_s_d   = '0;
        change_m_d   = '0;
        alu_op_d     = '0;
        inta_d       = '0;
        case (nst)
            FETCH: begin
                write_pc_d = 1'b1;
                write_ir_d = 1'b1;
            end
            EXEC: begin
                write_reg_d = 1'b1;
                alu_op_d    = ir[24:21];
                s_d         = ir[20];
            end
            RET_ALU: begin
                alu_op_d = 4'b1000;
                s_d      = 1'b1;
            end
            RET_WB: begin
                alu_op_d     = 4'b1000;
                write_pc_d   = 1'b1;
                pc_s_d       = 2'd2;
                write_cpsr_d = 1'b1;
                sp_out_d     = 1'b1;
            end
            CHECK: sp_in_d = 1'b1;
            EXC_LR: begin
                alu_op_d  = 4'b1000;
                alu_a_s_d = 2'd1;
            end
            EXC_SAVE: begin
                alu_op_d     = 4'b1000;
                alu_a_s_d    = 2'd1;
                change_m_d   = exc_fiq_q ? 3'b010 : 3'b001;
                rd_s_d       = 2'd1;
                write_reg_d  = 1'b1;
                write_spsr_d = 1'b1;
                w_spsr_s_d   = 1'b1;
            end
            EXC_JUMP: begin
                change_m_d   = exc_fiq_q ? 3'b010 : 3'b001;
                write_cpsr_d = 1'b1;
                w_cpsr_s_d   = exc_fiq_q ? 3'b011 : 3'b010;
                write_pc_d   = 1'b1;
                pc_s_d       = 2'd3;
                fiqa_d       = exc_fiq_q;
                for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                    inta_d[i] = !exc_fiq_q && (irq_id == ID_W'(i));
                end
            end
            default: ;
        endcase
    end

    // State, exception latch and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= IDLE;
            exc_fiq_q  <= 1'b0;
            irq_id     <= '0;
            exc_vec    <= '0;
            write_reg  <= 1'b0;
            write_pc   <= 1'b0;
            write_ir   <= 1'b0;
            write_cpsr <= 1'b0;
            write_spsr <= 1'b0;
            s          <= 1'b0;
            sp_in      <= 1'b0;
            sp_out     <= 1'b0;
            w_spsr_s   <= 1'b0;
            fiqa       <= 1'b0;
            w_rdata_s  <= '0;
            rd_s       <= '0;
            alu_a_s    <= '0;
            pc_s       <= '0;
            w_cpsr_s   <= '0;
            change_m   <= '0;
            alu_op     <= '0;
            inta       <= '0;
        end else begin
            st_q <= nst;
            // irq_id keeps the last serviced IRQ line across an FIQ entry
            if (st_q == CHECK && (fiq_take || irq_take)) begin
                exc_fiq_q <= fiq_take;
                if (!fiq_take) irq_id <= irq_sel;
                exc_vec   <= fiq_take ? 32'h0000_001C : irq_vec;
            end
            write_reg  <= write_reg_d;
            write_pc   <= write_pc_d;
            write_ir   <= write_ir_d;
            write_cpsr <= write_cpsr_d;
            write_spsr <= write_spsr_d;
            s          <= s_d;
            sp_in      <= sp_in_d;
            sp_out     <= sp_out_d;
            w_spsr_s   <= w_spsr_s_d;
            fiqa       <= fiqa_d;
            w_rdata_s  <= w_rdata_s_d;
            rd_s       <= rd_s_d;
            alu_a_s    <= alu_a_s_d;
            pc_s       <= pc_s_d;
            w_cpsr_s   <= w_cpsr_s_d;
            change_m   <= change_m_d;
            alu_op     <= alu_op_d;
            inta       <= inta_d;
        end
    end

endmodule

// File: tb/tb_arm_exc_sequencer.sv
// Testbench for arm_exc_sequencer: table of instruction/interrupt episodes
// plus randomized episodes, each checked cycle by cycle against an
// episode-level reference model of the sequencer.
module tb_arm_exc_sequencer;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_RET_ALU = 4;
    localparam int S_RET_WB = 5, S_CHECK = 6, S_EXC_LR = 7, S_EXC_SAVE = 8, S_EXC_JUMP = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_req, irq_en;
    logic        fiq_req;
    logic [31:0] ir, cpsr;
    logic        write_reg, write_pc, write_ir, write_cpsr, write_spsr;
    logic        s, sp_in, sp_out, w_spsr_s, fiqa;
    logic [1:0]  w_rdata_s, rd_s, alu_a_s, pc_s, irq_id;
    logic [2:0]  w_cpsr_s, change_m;
    logic [3:0]  alu_op, inta;
    logic [31:0] exc_vec;
    logic [4:0]  st, next_st;

    arm_exc_sequencer #(.NUM_IRQ(4), .IRQ_VEC_BASE(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .irq_req(irq_req), .irq_en(irq_en), .fiq_req(fiq_req),
        .ir(ir), .cpsr(cpsr), .write_reg(write_reg), .write_pc(write_pc),
        .write_ir(write_ir), .write_cpsr(write_cpsr), .write_spsr(write_spsr), .s(s),
        .sp_in(sp_in), .sp_out(sp_out), .w_spsr_s(w_spsr_s), .w_rdata_s(w_rdata_s),
        .rd_s(rd_s), .alu_a_s(alu_a_s), .pc_s(pc_s), .w_cpsr_s(w_cpsr_s),
        .change_m(change_m), .alu_op(alu_op), .inta(inta), .fiqa(fiqa),
        .irq_id(irq_id), .exc_vec(exc_vec), .st(st), .next_st(next_st)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_bad = 0, ep_len = 0;
    logic        m_fiq = 1'b0;
    logic [1:0]  m_id  = 2'd0;
    logic [31:0] m_vec = 32'd0;

    typedef struct {
        logic [31:0] ir;
        logic [3:0]  req, en;
        logic        fiq;
        logic [31:0] cpsr;
        logic        late;
        int          len;
        logic        jump;
        logic [3:0]  inta;
        logic        fiqa;
        logic [1:0]  id;
        logic [31:0] vec;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] irq_vector(input logic [1:0] id);
`ifdef VECTORED_IRQ_EN
        return 32'h100 + 32'(id) * 4;
`else
        return 32'h18;
`endif
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Expected control word for a state, from the per-state output table
    function automatic logic [31:0] exp_ctl(input int sn, input logic [31:0] irv);
        logic wreg, wpc, wir, wcpsr, wspsr, sb, spi, spo, wss, fa;
        logic [1:0] wrd, rds, aas, pcs;
        logic [2:0] wcs, cm;
        logic [3:0] op, ia;
        {wreg, wpc, wir, wcpsr, wspsr, sb, spi, spo, wss, fa} = '0;
        {wrd, rds, aas, pcs, wcs, cm, op, ia} = '0;
        case (sn)
            S_FETCH:    begin wpc = 1; wir = 1; end
            S_EXEC:     begin wreg = 1; op = irv[24:21]; sb = irv[20]; end
            S_RET_ALU:  begin op = 4'b1000; sb = 1; end
            S_RET_WB:   begin op = 4'b1000; wpc = 1; pcs = 2; wcpsr = 1; spo = 1; end
            S_CHECK:    spi = 1;
            S_EXC_LR:   begin op = 4'b1000; aas = 1; end
            S_EXC_SAVE: begin
                op = 4'b1000; aas = 1; cm = m_fiq ? 3'd2 : 3'd1;
                rds = 1; wreg = 1; wspsr = 1; wss = 1;
            end
            S_EXC_JUMP: begin
                cm = m_fiq ? 3'd2 : 3'd1; wcpsr = 1; wcs = m_fiq ? 3'd3 : 3'd2;
                wpc = 1; pcs = 3;
                if (m_fiq) fa = 1; else ia = 4'b0001 << m_id;
            end
            default: ;
        endcase
        return {wreg, wpc, wir, wcpsr, wspsr, sb, spi, spo, wss, wrd, rds, aas, pcs,
                wcs, cm, op, ia, fa};
    endfunction

    function automatic logic [75:0] observed();
        return {write_reg, write_pc, write_ir, write_cpsr, write_spsr, s, sp_in, sp_out,
                w_spsr_s, w_rdata_s, rd_s, alu_a_s, pc_s, w_cpsr_s, change_m, alu_op,
                inta, fiqa, irq_id, exc_vec, st, next_st};
    endfunction

    task automatic check(input string name, input logic [75:0] e, input logic [75:0] a);
        n_vec++;
        if (e !== a) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic step(input int e_st, input int e_nx);
        @(posedge clk);
        #1;
        ep_len++;
        check($sformatf("state%0d", e_st),
              {exp_ctl(e_st, ir), m_id, m_vec, 5'(e_st), 5'(e_nx)}, observed());
    endtask

    // One instruction followed by any exception entries it triggers;
    // acts as the CPU/interrupt source after each acknowledge.
    task automatic run_episode(input logic [31:0] ir_v, input logic [3:0] req_v,
                               input logic [3:0] en_v, input logic fiq_v,
                               input logic [31:0] cpsr_v, input logic late_fiq,
                               output int len, output logic jumped,
                               output logic [3:0] j_inta, output logic j_fiqa,
                               output logic [1:0] j_id, output logic [31:0] j_vec);
        logic movs, tf, ti;
        ep_len = 0; jumped = 0; j_inta = 0; j_fiqa = 0; j_id = 0; j_vec = 0;
        step(S_FETCH, S_DECODE);
        ir = ir_v; irq_req = req_v; irq_en = en_v; fiq_req = fiq_v; cpsr = cpsr_v;
        movs = (ir_v[27:25] == 3'b000) && !ir_v[4] && (ir_v[15:12] == 4'hF);
        step(S_DECODE, movs ? S_RET_ALU : S_EXEC);
        if (movs) begin
            step(S_RET_ALU, S_RET_WB);
            step(S_RET_WB, S_CHECK);
        end else begin
            step(S_EXEC, S_CHECK);
        end
        for (int n = 0; n < 4; n++) begin
            tf = fiq_req && !cpsr[6];
            ti = ((irq_req & irq_en) != 4'b0) && !cpsr[7];
            step(S_CHECK, (tf || ti) ? S_EXC_LR : S_FETCH);
            if (!(tf || ti)) break;
            m_fiq = tf;
            if (!tf) m_id = lowest(irq_req & irq_en);
            m_vec = tf ? 32'h1C : irq_vector(m_id);
            step(S_EXC_LR, S_EXC_SAVE);
            if (late_fiq) begin
                fiq_req = 1'b1;
                late_fiq = 1'b0;
            end
            step(S_EXC_SAVE, S_EXC_JUMP);
            step(S_EXC_JUMP, S_CHECK);
            if (!jumped) begin
                jumped = 1; j_inta = inta; j_fiqa = fiqa; j_id = irq_id; j_vec = exc_vec;
            end
            if (m_fiq) begin
                fiq_req = 1'b0;
                cpsr[7:6] = 2'b11;
            end else begin
                irq_req[m_id] = 1'b0;
                cpsr[7] = 1'b1;
            end
        end
        len = ep_len;
    endtask

    initial begin
        int          len;
        logic        jmp, jf;
        logic [3:0]  ji;
        logic [1:0]  jid;
        logic [31:0] jv, rir;

        tbl[0] = '{32'hE0812003, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0, 4, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[1] = '{32'hE1B0F00E, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0, 5, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[2] = '{32'hE0812003, 4'b1010, 4'hF, 1'b0, 32'h0, 1'b0, 8, 1'b1, 4'b0010, 1'b0, 2'd1, irq_vector(1)};
        tbl[3] = '{32'hE0812003, 4'b0001, 4'hF, 1'b1, 32'h0, 1'b0, 8, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h1C};
        tbl[4] = '{32'hE0912003, 4'b0100, 4'hF, 1'b0, 32'h93, 1'b0, 4, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[5] = '{32'hE0412003, 4'b0100, 4'b1011, 1'b0, 32'h0, 1'b0, 4, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[6] = '{32'hE0812003, 4'b0001, 4'hF, 1'b0, 32'h0, 1'b1, 12, 1'b1, 4'b0001, 1'b0, 2'd0, irq_vector(0)};
        tbl[7] = '{32'hE1A00001, 4'b1100, 4'hF, 1'b0, 32'h0, 1'b0, 8, 1'b1, 4'b0100, 1'b0, 2'd2, irq_vector(2)};
        tbl[8] = '{32'hE0812003, 4'b1111, 4'b1000, 1'b0, 32'h0, 1'b0, 8, 1'b1, 4'b1000, 1'b0, 2'd3, irq_vector(3)};
        tbl[9] = '{32'hE1B0F00E, 4'b0010, 4'hF, 1'b0, 32'h0, 1'b0, 9, 1'b1, 4'b0010, 1'b0, 2'd1, irq_vector(1)};

        rst = 1'b1; irq_req = 0; irq_en = 0; fiq_req = 0; ir = 32'hE0812003; cpsr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 76'd0, observed());
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle", {32'd0, 2'd0, 32'd0, 5'd0, 5'd1}, observed());

        for (int k = 0; k < 10; k++) begin
            run_episode(tbl[k].ir, tbl[k].req, tbl[k].en, tbl[k].fiq, tbl[k].cpsr,
                        tbl[k].late, len, jmp, ji, jf, jid, jv);
            check($sformatf("len%0d", k), 76'(tbl[k].len), 76'(len));
            check($sformatf("taken%0d", k), 76'(tbl[k].jump), 76'(jmp));
            if (tbl[k].jump)
                check($sformatf("ack%0d", k), {37'd0, tbl[k].inta, tbl[k].fiqa, tbl[k].id, tbl[k].vec},
                      {37'd0, ji, jf, jid, jv});
        end

        // Asynchronous reset landing in the EXC_JUMP cycle
        step(S_FETCH, S_DECODE);
        ir = 32'hE0812003; irq_req = 4'b0010; irq_en = 4'hF; fiq_req = 0; cpsr = 0;
        step(S_DECODE, S_EXEC);
        step(S_EXEC, S_CHECK);
        step(S_CHECK, S_EXC_LR);
        m_fiq = 0; m_id = 2'd1; m_vec = irq_vector(1);
        step(S_EXC_LR, S_EXC_SAVE);
        step(S_EXC_SAVE, S_EXC_JUMP);
        step(S_EXC_JUMP, S_CHECK);
        #2;
        rst = 1'b1;
        #1;
        m_fiq = 0; m_id = 0; m_vec = 0;
        check("rst_in_jump", 76'd0, observed());
        irq_req = 0; irq_en = 0; cpsr = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_after_rst", {32'd0, 2'd0, 32'd0, 5'd0, 5'd1}, observed());
        run_episode(32'hE0812003, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0, len, jmp, ji, jf, jid, jv);
        check("len_after_rst", 76'd4, 76'(len));

        for (int k = 0; k < 40; k++) begin
            rir = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                rir[27:25] = 3'b000; rir[4] = 1'b0; rir[15:12] = 4'hF;
            end
            run_episode(rir, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0),
                        len, jmp, ji, jf, jid, jv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
